// File: rtl/data_mem_mmio_if.sv
// MEM-stage data bus between the EX/MEM pipeline register and data_mem_mmio.
// The master drives the load/store controls; the slave returns combinational load data.
interface data_mem_mmio_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output MemRead,
        output MemWrite,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/data_mem_mmio.sv
// MEM-stage data RAM with memory-mapped timer (TH/TL/TCON), LED and 7-seg digit registers.
// Define SYSTICK_EN to add a read-only free-running SYSTICK counter at 0x40000014.
module data_mem_mmio #(
    parameter int unsigned RAM_WORDS = 256,
    parameter int unsigned RAM_AW    = 8
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_mmio_if.slave     bus,
    output logic [7:0]         leds,
    output logic [11:0]        digits,
    output logic               irq
);

    localparam logic [29:0] TH_WORD      = 30'h1000_0000;
    localparam logic [29:0] TL_WORD      = 30'h1000_0001;
    localparam logic [29:0] TCON_WORD    = 30'h1000_0002;
    localparam logic [29:0] LEDS_WORD    = 30'h1000_0003;
    localparam logic [29:0] DIGI_WORD    = 30'h1000_0004;
`ifdef SYSTICK_EN
    localparam logic [29:0] SYSTICK_WORD = 30'h1000_0005;
`endif

    logic [29:0] wordAddr;
    logic        selRam;
    logic        selTH;
    logic        selTL;
    logic        selTCON;
    logic        selLeds;
    logic        selDigi;
    logic        wrTH;
    logic        wrTL;
    logic        wrTCON;
    logic        unusedByteOffset;

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [31:0] ram [RAM_WORDS];

    assign wordAddr         = bus.addr[31:2];
    assign unusedByteOffset = ^bus.addr[1:0];

    always_comb begin
        selRam  = (bus.addr[31:RAM_AW+2] == '0);
        selTH   = (wordAddr == TH_WORD);
        selTL   = (wordAddr == TL_WORD);
        selTCON = (wordAddr == TCON_WORD);
        selLeds = (wordAddr == LEDS_WORD);
        selDigi = (wordAddr == DIGI_WORD);
        wrTH    = bus.MemWrite && selTH;
        wrTL    = bus.MemWrite && selTL;
        wrTCON  = bus.MemWrite && selTCON;
    end

    // RAM has no reset so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (bus.MemWrite && selRam) begin
            ram[bus.addr[RAM_AW+1:2]] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th     <= '0;
            tl     <= '0;
            tcon   <= '0;
            leds   <= '0;
            digits <= '0;
        end else begin
            // A CPU write to TL or TCON suppresses this edge's timer step entirely.
            if (tcon[0] && !wrTL && !wrTCON) begin
                if (tl == '1) begin
                    tl <= th;
                    if (tcon[1]) begin
                        tcon[2] <= 1'b1;
                    end
                end else begin
                    tl <= tl + 32'd1;
                end
            end
            if (wrTH) begin
                th <= bus.wdata;
            end
            if (wrTL) begin
                tl <= bus.wdata;
            end
            if (wrTCON) begin
                tcon <= bus.wdata[2:0];
            end
            if (bus.MemWrite && selLeds) begin
                leds <= bus.wdata[7:0];
            end
            if (bus.MemWrite && selDigi) begin
                digits <= bus.wdata[11:0];
            end
        end
    end

`ifdef SYSTICK_EN
    logic [31:0] systick;
    logic        selSystick;

    assign selSystick = (wordAddr == SYSTICK_WORD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end
`endif

    always_comb begin
        irq = tcon[2] & tcon[1];
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.MemRead) begin
            if (selRam) begin
                bus.rdata = ram[bus.addr[RAM_AW+1:2]];
            end else if (selTH) begin
                bus.rdata = th;
            end else if (selTL) begin
                bus.rdata = tl;
            end else if (selTCON) begin
                bus.rdata = {29'd0, tcon};
            end else if (selLeds) begin
                bus.rdata = {24'd0, leds};
            end else if (selDigi) begin
                bus.rdata = {20'd0, digits};
            end
`ifdef SYSTICK_EN
            else if (selSystick) begin
                bus.rdata = systick;
            end
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Randomized scoreboard bench for data_mem_mmio: a driver pushes expected outputs
// computed from a behavioural memory-map model; a negedge monitor pops and compares.
module tb_data_mem_mmio;

    localparam logic [31:0] A_TH      = 32'h4000_0000;
    localparam logic [31:0] A_TL      = 32'h4000_0004;
    localparam logic [31:0] A_TCON    = 32'h4000_0008;
    localparam logic [31:0] A_LEDS    = 32'h4000_000C;
    localparam logic [31:0] A_DIGI    = 32'h4000_0010;
    localparam logic [31:0] A_SYSTICK = 32'h4000_0014;
    localparam logic [31:0] RAM_BYTES = 32'd1024;

    logic clk = 1'b0;
    logic reset;
    logic [7:0]  leds;
    logic [11:0] digits;
    logic        irq;

    always #5 clk = ~clk;

    data_mem_mmio_if bus();

    data_mem_mmio #(.RAM_WORDS(256), .RAM_AW(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .leds   (leds),
        .digits (digits),
        .irq    (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [7:0]  leds;
        logic [11:0] digits;
        logic        irq;
    } exp_t;

    exp_t expQ[$];
    int compared   = 0;
    int mismatched = 0;

    // Behavioural model of the memory map
    logic [31:0] mTH, mTL, mSys;
    logic [2:0]  mTCON;
    logic [7:0]  mLeds;
    logic [11:0] mDigi;
    logic [31:0] mRam [int];

    function automatic void check(string n, string f, logic [31:0] act, logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s.%s: got 0x%08h required 0x%08h", n, f, act, req);
        end
    endfunction

    function automatic void modelReset();
        mTH = '0; mTL = '0; mTCON = '0; mLeds = '0; mDigi = '0; mSys = '0;
    endfunction

    function automatic logic [31:0] modelRead(logic rd, logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (!rd) return '0;
        if (w < RAM_BYTES) return mRam.exists(int'(w >> 2)) ? mRam[int'(w >> 2)] : '0;
        case (w)
            A_TH:      return mTH;
            A_TL:      return mTL;
            A_TCON:    return {29'd0, mTCON};
            A_LEDS:    return {24'd0, mLeds};
            A_DIGI:    return {20'd0, mDigi};
`ifdef SYSTICK_EN
            A_SYSTICK: return mSys;
`endif
            default:   return '0;
        endcase
    endfunction

    function automatic void modelEdge(logic wr, logic [31:0] a, logic [31:0] wd);
        logic [31:0] w;
        logic cpuTL, cpuTCON;
        w       = {a[31:2], 2'b00};
        cpuTL   = wr && (w == A_TL);
        cpuTCON = wr && (w == A_TCON);
        if (mTCON[0] && !cpuTL && !cpuTCON) begin
            if (mTL == 32'hFFFF_FFFF) begin
                mTL = mTH;
                if (mTCON[1]) mTCON[2] = 1'b1;
            end else begin
                mTL = mTL + 1;
            end
        end
        if (wr) begin
            if (w < RAM_BYTES) mRam[int'(w >> 2)] = wd;
            else if (w == A_TH)   mTH   = wd;
            else if (w == A_TL)   mTL   = wd;
            else if (w == A_TCON) mTCON = wd[2:0];
            else if (w == A_LEDS) mLeds = wd[7:0];
            else if (w == A_DIGI) mDigi = wd[11:0];
        end
        mSys = mSys + 1;
    endfunction

    function automatic exp_t expectNow(string n, logic rd, logic [31:0] a);
        exp_t e;
        e.name   = n;
        e.rdata  = modelRead(rd, a);
        e.leds   = mLeds;
        e.digits = mDigi;
        e.irq    = mTCON[2] & mTCON[1];
        return e;
    endfunction

    // Called at posedge+1: drive one bus cycle, then advance the model over the edge.
    task automatic op(string n, logic rd, logic wr, logic [31:0] a, logic [31:0] wd);
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.addr     = a;
        bus.wdata    = wd;
        expQ.push_back(expectNow(n, rd, a));
        @(posedge clk);
        modelEdge(wr, a, wd);
        #1;
    endtask

    task automatic midCycleReset(string n);
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        #2;
        reset = 1'b1;
        modelReset();
        expQ.push_back(expectNow(n, 1'b0, '0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            exp_t e;
            e = expQ.pop_front();
            check(e.name, "rdata",  bus.rdata,         e.rdata);
            check(e.name, "leds",   {24'd0, leds},     {24'd0, e.leds});
            check(e.name, "digits", {20'd0, digits},   {20'd0, e.digits});
            check(e.name, "irq",    {31'd0, irq},      {31'd0, e.irq});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, wd;
        logic rd, wr;
        reset        = 1'b1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        op("rst_tcon",  1, 0, A_TCON, 0);
        op("ram_wr",    0, 1, 32'h10, 32'h1234_5678);
        op("ram_rd",    1, 0, 32'h10, 0);
        op("ram_unwr",  1, 0, 32'h14, 0);
        op("ram_rw",    1, 1, 32'h10, 32'hCAFE_F00D);
        op("ram_rd2",   1, 0, 32'h13, 0);

        op("t_th",      0, 1, A_TH,   32'hFFFF_FFFD);
        op("t_tl",      0, 1, A_TL,   32'hFFFF_FFFE);
        op("t_tcon",    0, 1, A_TCON, 32'h3);
        op("t_rd1",     1, 0, A_TL,   0);
        op("t_rd2",     1, 0, A_TL,   0);
        op("t_tcon7",   1, 0, A_TCON, 0);
        op("t_clr",     0, 1, A_TCON, 32'h3);
        op("t_irq0",    1, 0, A_TCON, 0);

        op("c_off",     0, 1, A_TCON, 32'h0);
        op("c_tl",      0, 1, A_TL,   32'hFFFF_FFFF);
        op("c_on",      0, 1, A_TCON, 32'h3);
        op("c_hit",     1, 1, A_TL,   32'h5);
        op("c_tl5",     1, 0, A_TL,   0);
        op("c_tcon",    1, 0, A_TCON, 0);

        op("m_leds",    0, 1, A_LEDS, 32'h1A5);
        op("m_ledrd",   1, 0, A_LEDS, 0);
        op("m_digi",    0, 1, A_DIGI, 32'hABCD);
        op("m_digrd",   1, 0, A_DIGI, 0);
        op("m_unmap",   1, 0, 32'h4000_0020, 0);
        op("m_nord",    0, 0, A_LEDS, 0);
        op("m_ramhi",   1, 1, 32'h400, 32'h5555_AAAA);
        op("m_ram0",    1, 0, 32'h0, 0);

        op("r_tl",      0, 1, A_TL,   32'h100);
        op("r_tcon",    0, 1, A_TCON, 32'h7);
        op("r_pre",     1, 0, A_TL,   0);
        midCycleReset("r_async");

        for (int i = 0; i < 10; i++) op("s_idle", 0, 0, 0, 0);
        op("s_tick",    1, 0, A_SYSTICK, 0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 11))
                0, 1, 2, 3: a = 32'($urandom_range(0, 31)) << 2;
                4:  a = A_TH;
                5:  a = A_TL;
                6:  a = A_TCON;
                7:  a = A_LEDS;
                8:  a = A_DIGI;
                9:  a = A_SYSTICK;
                10: a = 32'h4000_0020;
                default: a = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h0000_0400;
            endcase
            a  = a | 32'($urandom_range(0, 3));
            wd = $urandom;
            if ({a[31:2], 2'b00} == A_TL && $urandom_range(0, 1) == 1)
                wd = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
            if ({a[31:2], 2'b00} == A_TH && $urandom_range(0, 1) == 1)
                wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if ({a[31:2], 2'b00} == A_TCON && $urandom_range(0, 3) != 0)
                wd = {29'($urandom), 3'b011} | 32'($urandom_range(0, 4));
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 2) == 0);
            op("rand", rd, wr, a, wd);
            if ($urandom_range(0, 150) == 0) midCycleReset("rand_rst");
        end

        @(negedge clk);
        #1;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
